corevx_ptw: RTL and testbench

Sv32 page-table walker that sits directly upstream of the TLB ways. On a TLB miss the block walks the two-level page table through a simple memory read port. It returns a completed translation (virtual page, 8-bit accesstag, 22-bit physical page) in exactly the form the TLB write port consumes, or it reports a page or access fault. One walk is in flight at a time.

---
 rtl/corevx_ptw_pkg.sv | 28 ++
 rtl/corevx_ptw_pte_check.sv | 34 +++
 rtl/corevx_ptw.sv | 148 ++++++++++++++
 tb/tb_corevx_ptw.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corevx_ptw_pkg.sv
// Shared types and PTE field positions for the Sv32 page-table walker.
// Pure declarations, no logic.
package corevx_ptw_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    RESPOND  = 2'd2
  } state_e;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;

  localparam int          PTE_PPN_LSB    = 10;
  localparam logic [7:0]  BARE_ACCESSTAG = 8'hCF;

  // Byte address of a PTE: table base page, 10-bit index, 4-byte entries.
  function automatic logic [33:0] pte_addr(input logic [21:0] ppn, input logic [9:0] idx);
    return {ppn, idx, 2'b00};
  endfunction

endpackage

// File: rtl/corevx_ptw_pte_check.sv
// Combinational Sv32 PTE classifier: leaf detect, fault detect, resulting physical page.
// Build option COREVX_PTW_AD_CHECK_EN: a leaf with A=0 is a page fault.
module corevx_ptw_pte_check
  import corevx_ptw_pkg::*;
(
  input  logic [31:0] pte,
  input  logic        level,
  input  logic [9:0]  vpn0,
  output logic        leaf,
  output logic        fault,
  output logic [21:0] phys
);

  logic unused_bits;

  always_comb begin
    leaf  = pte[PTE_R] | pte[PTE_X];
    fault = !pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W]);
    // A level-1 leaf must map a 4 MiB aligned superpage.
    if (leaf && level && (pte[19:PTE_PPN_LSB] != 10'd0)) fault = 1'b1;
    if (!leaf && !level) fault = 1'b1;
`ifdef COREVX_PTW_AD_CHECK_EN
    if (leaf && !pte[PTE_A]) fault = 1'b1;
`endif
    phys = level ? {pte[31:20], vpn0} : pte[31:PTE_PPN_LSB];
  end

`ifdef COREVX_PTW_AD_CHECK_EN
  assign unused_bits = ^{pte[9:8], pte[PTE_D], pte[PTE_G], pte[PTE_U]};
`else
  assign unused_bits = ^{pte[9:8], pte[PTE_D], pte[PTE_A], pte[PTE_G], pte[PTE_U]};
`endif

endmodule

// File: rtl/corevx_ptw.sv
// Sv32 page-table walker feeding the TLB write port; one walk in flight, options COREVX_PTW_AD_CHECK_EN / COREVX_PTW_DEBUG_EN.
// Bare: done 1 cycle after request; Sv32: one cycle per read plus a gap cycle and a respond cycle; requests while busy are dropped.
module corevx_ptw
  import corevx_ptw_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 0,
  parameter bit disable_debug = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resolve_request,
  input  logic [19:0] resolve_virtual_address,
  input  logic        satp_mode,
  input  logic [21:0] satp_ppn,
  output logic        resolve_busy,
  output logic        resolve_done,
  output logic        resolve_pagefault,
  output logic        resolve_accessfault,
  output logic [19:0] virtual_address_w,
  output logic [7:0]  accesstag_w,
  output logic [21:0] phys_w,
  output logic        m_read,
  output logic [33:0] m_addr,
  input  logic        m_done,
  input  logic [31:0] m_rdata,
  input  logic        m_rerror
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] CNT_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e        state, state_next;
  logic          level;
  logic          gap;
  logic [TW-1:0] cnt;
  logic          rd_active;
  logic          rd_ok;
  logic          timeout_hit;
  logic          chk_leaf, chk_fault;
  logic [21:0]   chk_phys;

  corevx_ptw_pte_check u_pte_check (
    .pte   (m_rdata),
    .level (level),
    .vpn0  (virtual_address_w[9:0]),
    .leaf  (chk_leaf),
    .fault (chk_fault),
    .phys  (chk_phys)
  );

  // The gap cycle separates the two reads so the memory sees a fresh request edge.
  assign rd_active    = (state == WAIT_MEM) && !gap;
  assign rd_ok        = rd_active && m_done && !m_rerror;
  assign timeout_hit  = (MEM_TIMEOUT > 0) && rd_active && !m_done && (cnt == CNT_LAST);
  assign m_read       = rd_active;
  assign resolve_busy = (state != IDLE);
  assign resolve_done = (state == RESPOND);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (resolve_request) state_next = satp_mode ? WAIT_MEM : RESPOND;
      end
      WAIT_MEM: begin
        if (rd_active && m_done) begin
          if (m_rerror || chk_fault || chk_leaf) state_next = RESPOND;
        end else if (timeout_hit) begin
          state_next = RESPOND;
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level               <= 1'b0;
      gap                 <= 1'b0;
      cnt                 <= '0;
      resolve_pagefault   <= 1'b0;
      resolve_accessfault <= 1'b0;
      virtual_address_w   <= '0;
      accesstag_w         <= '0;
      phys_w              <= '0;
      m_addr              <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (resolve_request) begin
            virtual_address_w   <= resolve_virtual_address;
            resolve_pagefault   <= 1'b0;
            resolve_accessfault <= 1'b0;
            if (!satp_mode) begin
              phys_w      <= {2'b00, resolve_virtual_address};
              accesstag_w <= BARE_ACCESSTAG;
            end else begin
              level  <= 1'b1;
              gap    <= 1'b0;
              cnt    <= '0;
              m_addr <= pte_addr(satp_ppn, resolve_virtual_address[19:10]);
            end
          end
        end
        WAIT_MEM: begin
          if (gap) begin
            gap <= 1'b0;
            cnt <= '0;
          end else if (m_done && m_rerror) begin
            resolve_accessfault <= 1'b1;
            accesstag_w         <= 8'h00;
          end else if (rd_ok && chk_fault) begin
            resolve_pagefault <= 1'b1;
            accesstag_w       <= 8'h00;
          end else if (rd_ok && chk_leaf) begin
            phys_w      <= chk_phys;
            accesstag_w <= m_rdata[7:0];
          end else if (rd_ok) begin
            level  <= 1'b0;
            gap    <= 1'b1;
            cnt    <= '0;
            m_addr <= pte_addr(m_rdata[31:PTE_PPN_LSB], virtual_address_w[9:0]);
          end else if (timeout_hit) begin
            resolve_accessfault <= 1'b1;
            accesstag_w         <= 8'h00;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  if (!disable_debug) begin : g_debug
`ifdef COREVX_PTW_DEBUG_EN
    fault_excl: assert property (@(posedge clk) disable iff (rst)
      !(resolve_pagefault && resolve_accessfault));
`endif
  end

endmodule

// File: tb/tb_corevx_ptw.sv
// Directed self-checking bench for corevx_ptw with a zero-latency memory responder.
module tb_corevx_ptw;

  logic        clk = 1'b0;
  logic        rst;
  logic        resolve_request;
  logic [19:0] resolve_virtual_address;
  logic        satp_mode;
  logic [21:0] satp_ppn;
  logic        resolve_busy, resolve_done, resolve_pagefault, resolve_accessfault;
  logic [19:0] virtual_address_w;
  logic [7:0]  accesstag_w;
  logic [21:0] phys_w;
  logic        m_read;
  logic [33:0] m_addr;
  logic        m_done;
  logic [31:0] m_rdata;
  logic        m_rerror;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  corevx_ptw #(.MEM_TIMEOUT(8)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .resolve_request         (resolve_request),
    .resolve_virtual_address (resolve_virtual_address),
    .satp_mode               (satp_mode),
    .satp_ppn                (satp_ppn),
    .resolve_busy            (resolve_busy),
    .resolve_done            (resolve_done),
    .resolve_pagefault       (resolve_pagefault),
    .resolve_accessfault     (resolve_accessfault),
    .virtual_address_w       (virtual_address_w),
    .accesstag_w             (accesstag_w),
    .phys_w                  (phys_w),
    .m_read                  (m_read),
    .m_addr                  (m_addr),
    .m_done                  (m_done),
    .m_rdata                 (m_rdata),
    .m_rerror                (m_rerror)
  );

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic start_walk(input logic [19:0] va, input logic mode);
    resolve_request         = 1'b1;
    resolve_virtual_address = va;
    satp_mode               = mode;
    wait_clk();
    resolve_request = 1'b0;
  endtask

  // Waits (bounded) for m_read, answers it in that cycle, reports address and wait count.
  task automatic serve(input logic [31:0] data, input logic err,
                       output logic [33:0] addr, output int waited);
    waited = 0;
    while (!m_read && waited < 20) begin
      wait_clk();
      waited++;
    end
    addr = m_addr;
    if (m_read) begin
      m_rdata  = data;
      m_rerror = err;
      m_done   = 1'b1;
      wait_clk();
      m_done   = 1'b0;
      m_rerror = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk();
    wait_clk();
    n_checks++;
    if ({resolve_busy, resolve_done, resolve_pagefault, resolve_accessfault, m_read} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {resolve_busy, resolve_done, resolve_pagefault, resolve_accessfault, m_read});
    end
    n_checks++;
    if ({virtual_address_w, accesstag_w, phys_w, m_addr} !== 84'd0) begin
      n_fail++;
      $display("FAIL reset_data: va %h tag %h phys %h addr %h expected all zero",
               virtual_address_w, accesstag_w, phys_w, m_addr);
    end
    rst = 1'b0;
    wait_clk();
  endtask

  task automatic test_bare();
    start_walk(20'h00403, 1'b0);
    n_checks++;
    if ({resolve_done, resolve_busy, m_read, resolve_pagefault, resolve_accessfault} !== 5'b11000) begin
      n_fail++;
      $display("FAIL bare_done: done/busy/read/pf/af got %b expected 11000",
               {resolve_done, resolve_busy, m_read, resolve_pagefault, resolve_accessfault});
    end
    n_checks++;
    if (phys_w !== 22'h00403 || accesstag_w !== 8'hCF) begin
      n_fail++;
      $display("FAIL bare_result: phys %h tag %h expected 000403 cf", phys_w, accesstag_w);
    end
    wait_clk();
    n_checks++;
    if (resolve_done !== 1'b0 || resolve_busy !== 1'b0 || phys_w !== 22'h00403) begin
      n_fail++;
      $display("FAIL bare_idle_hold: done %b busy %b phys %h expected 0 0 000403",
               resolve_done, resolve_busy, phys_w);
    end
  endtask

  task automatic test_two_level();
    logic [33:0] a;
    int w;
    satp_ppn = 22'h00001;
    start_walk(20'h00403, 1'b1);
    serve(32'h00000801, 1'b0, a, w);
    n_checks++;
    if (a !== 34'h1004 || w !== 0) begin
      n_fail++;
      $display("FAIL walk_l1_addr: addr %h wait %0d expected 1004 0", a, w);
    end
    n_checks++;
    if (m_read !== 1'b0 || resolve_busy !== 1'b1 || resolve_done !== 1'b0) begin
      n_fail++;
      $display("FAIL walk_gap: read %b busy %b done %b expected 0 1 0", m_read, resolve_busy, resolve_done);
    end
    serve(32'h048D144F, 1'b0, a, w);
    n_checks++;
    if (a !== 34'h200C || w !== 1) begin
      n_fail++;
      $display("FAIL walk_l0_addr: addr %h gap %0d expected 200c 1", a, w);
    end
    n_checks++;
    if (resolve_done !== 1'b1 || resolve_pagefault !== 1'b0 || resolve_accessfault !== 1'b0) begin
      n_fail++;
      $display("FAIL walk_done: done %b pf %b af %b expected 1 0 0",
               resolve_done, resolve_pagefault, resolve_accessfault);
    end
    n_checks++;
    if (phys_w !== 22'h12345 || accesstag_w !== 8'h4F || virtual_address_w !== 20'h00403) begin
      n_fail++;
      $display("FAIL walk_result: phys %h tag %h va %h expected 012345 4f 00403",
               phys_w, accesstag_w, virtual_address_w);
    end
    wait_clk();
  endtask

  task automatic test_superpage();
    logic [33:0] a;
    int w;
    start_walk(20'h00403, 1'b1);
    serve(32'h0010004F, 1'b0, a, w);
    n_checks++;
    if (resolve_done !== 1'b1 || resolve_pagefault !== 1'b0 || phys_w !== 22'h00403 || accesstag_w !== 8'h4F) begin
      n_fail++;
      $display("FAIL superpage_ok: done %b pf %b phys %h tag %h expected 1 0 000403 4f",
               resolve_done, resolve_pagefault, phys_w, accesstag_w);
    end
    wait_clk();
    start_walk(20'h00403, 1'b1);
    serve(32'h0010044F, 1'b0, a, w);
    n_checks++;
    if (resolve_done !== 1'b1 || resolve_pagefault !== 1'b1 || resolve_accessfault !== 1'b0 ||
        accesstag_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL superpage_misaligned: done %b pf %b af %b tag0 %b expected 1 1 0 0",
               resolve_done, resolve_pagefault, resolve_accessfault, accesstag_w[0]);
    end
    wait_clk();
  endtask

  task automatic test_page_faults();
    logic [33:0] a;
    int w;
    start_walk(20'h00403, 1'b1);
    serve(32'h00000000, 1'b0, a, w);
    n_checks++;
    if (resolve_done !== 1'b1 || resolve_pagefault !== 1'b1 || resolve_accessfault !== 1'b0 ||
        accesstag_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL pf_invalid: done %b pf %b af %b tag0 %b expected 1 1 0 0",
               resolve_done, resolve_pagefault, resolve_accessfault, accesstag_w[0]);
    end
    wait_clk();
    start_walk(20'h00403, 1'b1);
    serve(32'h00000801, 1'b0, a, w);
    serve(32'h00000801, 1'b0, a, w);
    n_checks++;
    if (a !== 34'h200C || resolve_done !== 1'b1 || resolve_pagefault !== 1'b1 ||
        resolve_accessfault !== 1'b0 || accesstag_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL pf_l0_nonleaf: addr %h done %b pf %b af %b tag0 %b expected 200c 1 1 0 0",
               a, resolve_done, resolve_pagefault, resolve_accessfault, accesstag_w[0]);
    end
    wait_clk();
  endtask

  task automatic test_access_fault();
    logic [33:0] a;
    int w;
    start_walk(20'h00403, 1'b1);
    serve(32'h0010004F, 1'b1, a, w);
    n_checks++;
    if (resolve_done !== 1'b1 || resolve_accessfault !== 1'b1 || resolve_pagefault !== 1'b0 ||
        accesstag_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL af_rerror: done %b af %b pf %b tag0 %b expected 1 1 0 0",
               resolve_done, resolve_accessfault, resolve_pagefault, accesstag_w[0]);
    end
    wait_clk();
  endtask

  task automatic test_timeout();
    int n_rd = 0;
    int n = 0;
    start_walk(20'h00403, 1'b1);
    while (!resolve_done && n < 30) begin
      if (m_read) n_rd++;
      wait_clk();
      n++;
    end
    n_checks++;
    if (n_rd !== 8 || resolve_done !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_cycles: read cycles %0d done %b expected 8 1", n_rd, resolve_done);
    end
    n_checks++;
    if (resolve_accessfault !== 1'b1 || resolve_pagefault !== 1'b0 || m_read !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_flags: af %b pf %b read %b expected 1 0 0",
               resolve_accessfault, resolve_pagefault, m_read);
    end
    wait_clk();
  endtask

  task automatic test_reset_mid_walk();
    logic [33:0] a;
    int w;
    logic saw_done = 1'b0;
    start_walk(20'h00403, 1'b1);
    n_checks++;
    if (m_read !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: read %b expected 1", m_read);
    end
    rst = 1'b1;
    wait_clk();
    n_checks++;
    if (m_read !== 1'b0 || resolve_busy !== 1'b0 || resolve_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_idle: read %b busy %b done %b expected 0 0 0", m_read, resolve_busy, resolve_done);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (resolve_done) saw_done = 1'b1;
      wait_clk();
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_done: saw done %b expected 0", saw_done);
    end
    start_walk(20'h00403, 1'b1);
    serve(32'h0010004F, 1'b0, a, w);
    n_checks++;
    if (a !== 34'h1004 || resolve_done !== 1'b1 || phys_w !== 22'h00403 || resolve_pagefault !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_fresh: addr %h done %b phys %h pf %b expected 1004 1 000403 0",
               a, resolve_done, phys_w, resolve_pagefault);
    end
    wait_clk();
  endtask

  task automatic test_ignored_inputs();
    logic [33:0] a;
    int w;
    m_rdata = 32'h0010004F;
    m_done  = 1'b1;
    wait_clk();
    wait_clk();
    m_done = 1'b0;
    n_checks++;
    if (resolve_busy !== 1'b0 || resolve_done !== 1'b0 || m_read !== 1'b0 || phys_w !== 22'h00403) begin
      n_fail++;
      $display("FAIL idle_mdone: busy %b done %b read %b phys %h expected 0 0 0 000403",
               resolve_busy, resolve_done, m_read, phys_w);
    end
    satp_ppn = 22'h00002;
    start_walk(20'h00C07, 1'b1);
    resolve_request         = 1'b1;
    resolve_virtual_address = 20'hFFFFF;
    satp_mode               = 1'b0;
    serve(32'h0030008F, 1'b0, a, w);
    resolve_request = 1'b0;
    n_checks++;
    if (a !== 34'h200C || virtual_address_w !== 20'h00C07 || phys_w !== 22'h00C07 ||
        accesstag_w !== 8'h8F || resolve_done !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_request: addr %h va %h phys %h tag %h done %b expected 200c 00c07 000c07 8f 1",
               a, virtual_address_w, phys_w, accesstag_w, resolve_done);
    end
    wait_clk();
    n_checks++;
    if (resolve_busy !== 1'b0 || resolve_done !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_request_dropped: busy %b done %b expected 0 0", resolve_busy, resolve_done);
    end
  endtask

  initial begin
    rst                     = 1'b1;
    resolve_request         = 1'b0;
    resolve_virtual_address = '0;
    satp_mode               = 1'b0;
    satp_ppn                = '0;
    m_done                  = 1'b0;
    m_rdata                 = '0;
    m_rerror                = 1'b0;
    test_reset();
    test_bare();
    test_two_level();
    test_superpage();
    test_page_faults();
    test_access_fault();
    test_timeout();
    test_reset_mid_walk();
    test_ignored_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
